multiple_of_n_serial: RTL and testbench
=======================================

MULTIPLE_OF_N_SERIAL -- requirements
Module: multiple_of_n_serial

Interface
REQ-001 Parameter WIDTH, default 6: number of bits per input word.
REQ-002 Parameter N_A, default 3: first divisor; legal range 2..255.
REQ-003 Parameter N_B, default 5: second divisor; legal range 2..255.
REQ-004 Derived RA = clog2(N_A) and RB = clog2(N_B): remainder widths.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk, input, 1: sole clock; all state SHALL update on the rising edge.
REQ-007 reset, input, 1: synchronous, active-high reset.
REQ-008 start, input, 1: begin a new word.
REQ-009 bit_in, input, 1: serial data, MSB first.
REQ-010 bit_valid, input, 1: bit_in is valid this cycle.
REQ-011 busy, output, 1: high while a word is being accepted.
REQ-012 done, output, 1: one-cycle pulse when a result is posted.
REQ-013 ma, output, 1: last completed word is divisible by N_A.
REQ-014 mb, output, 1: last completed word is divisible by N_B.
REQ-015 rem_a, output, RA: value of the last completed word mod N_A.
REQ-016 rem_b, output, RB: value of the last completed word mod N_B.

Function
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 IDLE with start=1: go to SHIFT; clear the working remainders and the bit counter. bit_valid in that cycle SHALL be ignored.
REQ-019 SHIFT with bit_valid=1:
- ra <= (2*ra + bit_in) mod N_A
- rb <= (2*rb + bit_in) mod N_B
- counter increments by 1
REQ-020 Arithmetic SHALL be done at RA+1 / RB+1 bits with a single conditional subtract; no divider SHALL be inferred.
REQ-021 SHIFT with bit_valid=0: all state holds; gaps of any length are legal.
REQ-022 SHIFT with start=1: abort the current word; clear the remainders and counter; stay in SHIFT; bit_valid is ignored that cycle; done SHALL NOT pulse.
REQ-023 SHIFT, on the accepted bit that brings the count to WIDTH: go to DONE.
- Register rem_a and rem_b with the final values.
- ma = (final ra == 0); mb = (final rb == 0).
REQ-024 DONE: done=1 for exactly this one cycle, and the new results are visible in the same cycle. Latency SHALL be one cycle after the last accepted bit.
REQ-025 DONE to next state: IDLE; or SHIFT if start=1 in the DONE cycle, which SHALL behave exactly as REQ-018.
REQ-026 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-027 ma, mb, rem_a and rem_b SHALL hold their values until the next DONE; they SHALL NOT change during SHIFT.
REQ-028 An all-zero word SHALL give ma=1, mb=1, rem_a=0, rem_b=0.
REQ-029 bit_in and bit_valid SHALL be ignored in IDLE and DONE.
REQ-030 The counter SHALL be clog2(WIDTH+1) bits wide and SHALL never wrap within a word.

Reset
REQ-031 reset=1 SHALL take effect at the next rising edge and override all other inputs, including in mid-word.
REQ-032 Values after reset:
- state = IDLE; busy = 0; done = 0
- ma = 0; mb = 0; rem_a = 0; rem_b = 0
- working remainders and counter = 0
REQ-033 A word interrupted by reset SHALL produce no done pulse and SHALL leave no stale result.

Verification
REQ-034 Defaults, word 6'b101101 (45), contiguous valid -> done 1 cycle after the 6th bit; ma=1, mb=1, rem_a=0, rem_b=0.
REQ-035 Defaults, word 6'b000111 (7) -> ma=0, mb=0, rem_a=1, rem_b=2.
REQ-036 Defaults, word 0 -> ma=1, mb=1. Then word 45 sent with random bit_valid gaps -> identical result to REQ-034; busy high throughout; exactly one done pulse.
REQ-037 Defaults: 3 bits of 7, then start, then a full word 45 -> a single done with the results for 45. Also assert reset after 4 bits of a word -> no done; outputs all 0; busy=0 on the next cycle.
REQ-038 WIDTH=8, N_A=7, N_B=5, word 8'd91 -> ma=1, rem_a=0, mb=0, rem_b=1. Then start in the DONE cycle followed by word 8'd35 -> back-to-back done; ma=1, mb=1.

Source files
------------

// File: rtl/multiple_of_n_serial.sv
// multiple_of_n_serial: serial MSB-first word checker for divisibility by N_A and N_B.
// Running remainders are updated per accepted bit with one conditional subtract each.
`default_nettype none

module multiple_of_n_serial #(
  parameter int WIDTH = 6,
  parameter int N_A   = 3,
  parameter int N_B   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       ma,
  output logic                       mb,
  output logic [$clog2(N_A)-1:0]     rem_a,
  output logic [$clog2(N_B)-1:0]     rem_b
);

  localparam int RA = $clog2(N_A);
  localparam int RB = $clog2(N_B);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [RA:0]   NA_W = (RA + 1)'(N_A);
  localparam logic [RB:0]   NB_W = (RB + 1)'(N_B);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [RA-1:0]   ra, ra_n;
  logic [RB-1:0]   rb, rb_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            load;

  logic [RA:0]     ext_a, sub_a;
  logic [RB:0]     ext_b, sub_b;
  logic [RA-1:0]   step_a;
  logic [RB-1:0]   step_b;

  // 2*r + bit is always below 2*N, so one subtract brings it back into range.
  always_comb begin
    ext_a  = {ra, bit_in};
    ext_b  = {rb, bit_in};
    sub_a  = ext_a - NA_W;
    sub_b  = ext_b - NB_W;
    step_a = (ext_a >= NA_W) ? sub_a[RA-1:0] : ext_a[RA-1:0];
    step_b = (ext_b >= NB_W) ? sub_b[RB-1:0] : ext_b[RB-1:0];
  end

  always_comb begin
    state_n = state;
    ra_n    = ra;
    rb_n    = rb;
    cnt_n   = cnt;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          ra_n    = '0;
          rb_n    = '0;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          ra_n  = '0;
          rb_n  = '0;
          cnt_n = '0;
        end else if (bit_valid) begin
          ra_n  = step_a;
          rb_n  = step_b;
          cnt_n = cnt + CW'(1);
          if (cnt == LAST) begin
            state_n = DONE;
            load    = 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_n = SHIFT;
          ra_n    = '0;
          rb_n    = '0;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      cnt   <= '0;
      ma    <= 1'b0;
      mb    <= 1'b0;
      rem_a <= '0;
      rem_b <= '0;
    end else begin
      state <= state_n;
      ra    <= ra_n;
      rb    <= rb_n;
      cnt   <= cnt_n;
      if (load) begin
        rem_a <= step_a;
        rem_b <= step_b;
        ma    <= (step_a == '0);
        mb    <= (step_b == '0);
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_multiple_of_n_serial.sv
// tb_multiple_of_n_serial: directed checks of the serial divisibility checker,
// default configuration plus an 8-bit instance with N_A=7, N_B=5.
`default_nettype none

module tb_multiple_of_n_serial;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;

  logic       busy6, done6, ma6, mb6;
  logic [1:0] rem_a6;
  logic [2:0] rem_b6;
  logic       busy8, done8, ma8, mb8;
  logic [2:0] rem_a8;
  logic [2:0] rem_b8;

  int passed = 0;
  int total  = 0;
  int done6_cnt = 0;
  int done8_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  multiple_of_n_serial dut6 (
    .clk(clk), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy6), .done(done6), .ma(ma6), .mb(mb6), .rem_a(rem_a6), .rem_b(rem_b6)
  );

  multiple_of_n_serial #(.WIDTH(8), .N_A(7), .N_B(5)) dut8 (
    .clk(clk), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy8), .done(done8), .ma(ma8), .mb(mb8), .rem_a(rem_a8), .rem_b(rem_b8)
  );

  always @(negedge clk) begin
    if (done6) done6_cnt++;
    if (done8) done8_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Start cycle drives bit_valid=1/bit_in=1, which the design must ignore.
  task automatic begin_word(input bit sel8);
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    start = 1'b0; bit_valid = 1'b0;
    check("start_busy", sel8 ? busy8 : busy6, 1);
  endtask

  task automatic shift_bits(input logic [7:0] w, input int width, input int nbits,
                            input bit gaps, input bit sel8);
    for (int i = width - 1; i >= width - nbits; i--) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bit_valid = 1'b0; bit_in = 1'($urandom);
          step();
          check("gap_busy", sel8 ? busy8 : busy6, 1);
          check("gap_done", sel8 ? done8 : done6, 0);
        end
      end
      bit_valid = 1'b1; bit_in = w[i];
      step();
      if (i > 0) begin
        check("mid_busy", sel8 ? busy8 : busy6, 1);
        check("mid_done", sel8 ? done8 : done6, 0);
      end
    end
    bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic check6(input string tag, input logic m_a, input logic m_b,
                        input logic [1:0] r_a, input logic [2:0] r_b);
    check({tag, "_done"}, done6, 1);
    check({tag, "_busy"}, busy6, 0);
    check({tag, "_ma"}, ma6, m_a);
    check({tag, "_mb"}, mb6, m_b);
    check({tag, "_rem_a"}, rem_a6, r_a);
    check({tag, "_rem_b"}, rem_b6, r_b);
  endtask

  initial begin
    step();
    step();
    check("rst_busy", busy6, 0);
    check("rst_done", done6, 0);
    check("rst_ma", ma6, 0);
    check("rst_mb", mb6, 0);
    check("rst_rem_a", rem_a6, 0);
    check("rst_rem_b", rem_b6, 0);
    check("rst_busy8", busy8, 0);
    reset = 1'b0;

    // Idle with bit_valid asserted must not start anything.
    bit_valid = 1'b1; bit_in = 1'b1;
    step();
    check("idle_busy", busy6, 0);
    check("idle_done", done6, 0);

    // 45 contiguous: divisible by 3 and 5.
    begin_word(1'b0);
    shift_bits(8'd45, 6, 6, 1'b0, 1'b0);
    check6("w45", 1, 1, 2'd0, 3'd0);
    step();
    check("w45_after_done", done6, 0);
    check("w45_after_busy", busy6, 0);
    check("w45_hold_ma", ma6, 1);

    // 7: 7 mod 3 = 1, 7 mod 5 = 2.
    begin_word(1'b0);
    check("w7_hold_ma_in_shift", ma6, 1);
    shift_bits(8'd7, 6, 6, 1'b0, 1'b0);
    check6("w7", 0, 0, 2'd1, 3'd2);
    step();

    // All-zero word.
    begin_word(1'b0);
    check("w0_hold_rem_b", rem_b6, 2);
    shift_bits(8'd0, 6, 6, 1'b0, 1'b0);
    check6("w0", 1, 1, 2'd0, 3'd0);
    step();

    // 45 with random gaps: one done pulse, same result.
    snap = done6_cnt;
    begin_word(1'b0);
    shift_bits(8'd45, 6, 6, 1'b1, 1'b0);
    check6("w45g", 1, 1, 2'd0, 3'd0);
    step();
    step();
    check("w45g_one_done", done6_cnt, snap + 1);

    // Abort: 3 bits of 7, restart mid-word, full 45.
    begin_word(1'b0);
    shift_bits(8'd7, 6, 3, 1'b0, 1'b0);
    snap = done6_cnt;
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    start = 1'b0; bit_valid = 1'b0;
    check("abort_busy", busy6, 1);
    check("abort_done", done6, 0);
    shift_bits(8'd45, 6, 6, 1'b0, 1'b0);
    check6("abort45", 1, 1, 2'd0, 3'd0);
    step();
    check("abort_one_done", done6_cnt, snap + 1);

    // Leave a nonzero result, then reset after 4 bits of a word.
    begin_word(1'b0);
    shift_bits(8'd7, 6, 6, 1'b0, 1'b0);
    check6("pre_rst7", 0, 0, 2'd1, 3'd2);
    step();
    begin_word(1'b0);
    shift_bits(8'd45, 6, 4, 1'b0, 1'b0);
    snap = done6_cnt;
    reset = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", busy6, 0);
    check("midrst_done", done6, 0);
    check("midrst_ma", ma6, 0);
    check("midrst_mb", mb6, 0);
    check("midrst_rem_a", rem_a6, 0);
    check("midrst_rem_b", rem_b6, 0);
    repeat (4) step();
    bit_valid = 1'b0;
    check("midrst_no_done", done6_cnt, snap);
    check("midrst_idle", busy6, 0);

    // 8-bit instance: 91 then back-to-back 35.
    reset = 1'b1;
    step();
    reset = 1'b0;
    begin_word(1'b1);
    shift_bits(8'd91, 8, 8, 1'b0, 1'b1);
    check("w91_done", done8, 1);
    check("w91_ma", ma8, 1);
    check("w91_rem_a", rem_a8, 0);
    check("w91_mb", mb8, 0);
    check("w91_rem_b", rem_b8, 1);
    begin_word(1'b1);
    check("b2b_hold_rem_b", rem_b8, 1);
    shift_bits(8'd35, 8, 8, 1'b0, 1'b1);
    check("w35_done", done8, 1);
    check("w35_ma", ma8, 1);
    check("w35_mb", mb8, 1);
    check("w35_rem_a", rem_a8, 0);
    check("w35_rem_b", rem_b8, 0);
    step();
    check("w35_after_done", done8, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
